// File: rtl/lsu_ctrl.sv
// Load/store control stage: accepts one memory request, validates it, performs a
// single data-memory access cycle and holds a registered response for writeback.
//
// state  | meaning
// IDLE   | ready for a request; req_ready high
// ACCESS | one cycle driving the data memory port from latched request fields
// RESP   | response held on rsp_* until writeback accepts it
module lsu_ctrl #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        dm_we,
    output logic [31:0] dm_a,
    output logic [31:0] dm_wd,
    output logic [2:0]  dm_func3,
    input  logic [31:0] dm_rd,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic        rsp_is_load,
    output logic        rsp_fault,
    output logic [1:0]  rsp_cause
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0]  CAUSE_NONE    = 2'b00;
    localparam logic [1:0]  CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0]  CAUSE_RANGE   = 2'b10;
    localparam logic [1:0]  CAUSE_ILLEGAL = 2'b11;
    localparam logic [32:0] MEM_LIMIT     = 33'(MEM_BYTES);

    state_t      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        we_q, we_d;
    logic [2:0]  func3_q, func3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  rd_q, rd_d;
    logic        fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [4:0]  rsp_rd_q, rsp_rd_d;
    logic        rsp_is_load_q, rsp_is_load_d;
    logic        rsp_fault_q, rsp_fault_d;
    logic [1:0]  rsp_cause_q, rsp_cause_d;

    logic [2:0]  req_size;
    logic        chk_illegal;
    logic        chk_misalign;
    logic        chk_range;
    logic [32:0] req_end;
    logic [1:0]  req_cause;

    // Request validation; the 33-bit end address keeps 0xFFFFFFFF+size from wrapping.
    always_comb begin
        req_size = 3'd4;
        case (req_func3[1:0])
            2'b00:   req_size = 3'd1;
            2'b01:   req_size = 3'd2;
            default: req_size = 3'd4;
        endcase

        if (req_we) begin
            chk_illegal = !((req_func3 == 3'b000) || (req_func3 == 3'b001) ||
                            (req_func3 == 3'b010));
        end else begin
            chk_illegal = (req_func3 == 3'b011) || (req_func3 == 3'b110) ||
                          (req_func3 == 3'b111);
        end

        chk_misalign = ((req_size == 3'd2) && req_addr[0]) ||
                       ((req_size == 3'd4) && (req_addr[1:0] != 2'b00));

        req_end   = {1'b0, req_addr} + {30'd0, req_size};
        chk_range = req_end > MEM_LIMIT;

        if (chk_illegal) begin
            req_cause = CAUSE_ILLEGAL;
        end else if (chk_misalign) begin
            req_cause = CAUSE_MISALIGN;
        end else if (chk_range) begin
            req_cause = CAUSE_RANGE;
        end else begin
            req_cause = CAUSE_NONE;
        end
    end

    always_comb begin
        state_d       = state_q;
        req_ready_d   = req_ready_q;
        we_d          = we_q;
        func3_d       = func3_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rd_d          = rd_q;
        fault_d       = fault_q;
        cause_d       = cause_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_rd_d      = rsp_rd_q;
        rsp_is_load_d = rsp_is_load_q;
        rsp_fault_d   = rsp_fault_q;
        rsp_cause_d   = rsp_cause_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d        = req_we;
                    func3_d     = req_func3;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    rd_d        = req_rd;
                    fault_d     = (req_cause != CAUSE_NONE);
                    cause_d     = req_cause;
                    req_ready_d = 1'b0;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                rsp_data_d    = (!we_q && !fault_q) ? dm_rd : 32'd0;
                rsp_rd_d      = rd_q;
                rsp_is_load_d = !we_q;
                rsp_fault_d   = fault_q;
                rsp_cause_d   = cause_q;
                rsp_valid_d   = 1'b1;
                state_d       = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b1;
            we_q          <= 1'b0;
            func3_q       <= 3'b000;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            rd_q          <= 5'd0;
            fault_q       <= 1'b0;
            cause_q       <= CAUSE_NONE;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= 32'd0;
            rsp_rd_q      <= 5'd0;
            rsp_is_load_q <= 1'b0;
            rsp_fault_q   <= 1'b0;
            rsp_cause_q   <= CAUSE_NONE;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            we_q          <= we_d;
            func3_q       <= func3_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rd_q          <= rd_d;
            fault_q       <= fault_d;
            cause_q       <= cause_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_rd_q      <= rsp_rd_d;
            rsp_is_load_q <= rsp_is_load_d;
            rsp_fault_q   <= rsp_fault_d;
            rsp_cause_q   <= rsp_cause_d;
        end
    end

    // Reset gates the write enable combinationally so an interrupted store never lands.
    assign dm_we       = (state_q == ACCESS) && we_q && !fault_q && !rst;
    assign dm_a        = addr_q;
    assign dm_wd       = wdata_q;
    assign dm_func3    = func3_q;
    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_rd      = rsp_rd_q;
    assign rsp_is_load = rsp_is_load_q;
    assign rsp_fault   = rsp_fault_q;
    assign rsp_cause   = rsp_cause_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte-array memory model, vector table with a response
// scoreboard, plus hand sequences for backpressure and reset during ACCESS.
module tb_lsu_ctrl;
    localparam int unsigned MEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        dm_we;
    logic [31:0] dm_a;
    logic [31:0] dm_wd;
    logic [2:0]  dm_func3;
    logic [31:0] dm_rd;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_is_load;
    logic        rsp_fault;
    logic [1:0]  rsp_cause;

    always #5 clk = ~clk;

    lsu_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd),
        .dm_we(dm_we), .dm_a(dm_a), .dm_wd(dm_wd), .dm_func3(dm_func3),
        .dm_rd(dm_rd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_rd(rsp_rd), .rsp_is_load(rsp_is_load), .rsp_fault(rsp_fault),
        .rsp_cause(rsp_cause)
    );

    // Little-endian byte memory; counts every write-enabled edge.
    logic [7:0] mem [0:MEM_BYTES-1];
    int         wr_cnt = 0;
    logic [9:0] wa;
    logic [9:0] ra;
    logic [7:0] b0, b1, b2, b3;

    assign wa = dm_a[9:0];

    always @(posedge clk) begin
        if (dm_we) begin
            wr_cnt <= wr_cnt + 1;
            case (dm_func3)
                3'b000: mem[wa] <= dm_wd[7:0];
                3'b001: begin
                    mem[wa]         <= dm_wd[7:0];
                    mem[wa + 10'd1] <= dm_wd[15:8];
                end
                3'b010: begin
                    mem[wa]         <= dm_wd[7:0];
                    mem[wa + 10'd1] <= dm_wd[15:8];
                    mem[wa + 10'd2] <= dm_wd[23:16];
                    mem[wa + 10'd3] <= dm_wd[31:24];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ra = dm_a[9:0];
        b0 = mem[ra];
        b1 = mem[ra + 10'd1];
        b2 = mem[ra + 10'd2];
        b3 = mem[ra + 10'd3];
        dm_rd = 32'd0;
        case (dm_func3)
            3'b000:  dm_rd = {{24{b0[7]}}, b0};
            3'b001:  dm_rd = {{16{b1[7]}}, b1, b0};
            3'b010:  dm_rd = {b3, b2, b1, b0};
            3'b100:  dm_rd = {24'd0, b0};
            3'b101:  dm_rd = {16'd0, b1, b0};
            default: dm_rd = 32'd0;
        endcase
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] exp_data;
        logic        exp_fault;
        logic [1:0]  exp_cause;
        int          exp_wr;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        is_load;
        logic        fault;
        logic [1:0]  cause;
    } rsp_t;

    rsp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;
    vec_t vecs[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    task automatic drive_req(input vec_t v);
        req_we    = v.we;
        req_func3 = v.f3;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_rd    = v.rd;
        req_valid = 1'b1;
    endtask

    // Called just after a posedge; returns just after the accepting edge.
    task automatic wait_accept(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready && req_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            $display("FAIL %s_accept: actual=timeout required=accepted", tag);
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            req_addr  = $urandom();
            req_wdata = $urandom();
            req_func3 = 3'($urandom_range(0, 7));
            req_rd    = 5'($urandom_range(0, 31));
            req_we    = 1'($urandom_range(0, 1));
        end
    endtask

    // Called at a negedge sample point; pops and compares on the handshake.
    task automatic expect_rsp(input string tag);
        bit   seen;
        rsp_t e;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid && rsp_ready) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            checks++;
            $display("FAIL %s_rsp: actual=timeout required=response", tag);
        end else if (sb_q.size() == 0) begin
            checks++;
            $display("FAIL %s_sb: actual=unexpected_response required=none", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_data"},    rsp_data,    e.data);
            chk({tag, "_rd"},      32'(rsp_rd), 32'(e.rd));
            chk({tag, "_is_load"}, 32'(rsp_is_load), 32'(e.is_load));
            chk({tag, "_fault"},   32'(rsp_fault),   32'(e.fault));
            chk({tag, "_cause"},   32'(rsp_cause),   32'(e.cause));
        end
        @(posedge clk);
        #1;
    endtask

    function automatic rsp_t exp_of(input vec_t v);
        rsp_t e;
        e.data    = v.exp_data;
        e.rd      = v.rd;
        e.is_load = !v.we;
        e.fault   = v.exp_fault;
        e.cause   = v.exp_cause;
        return e;
    endfunction

    task automatic issue(input vec_t v, input string tag);
        bit ok;
        int w0;
        drive_req(v);
        wait_accept(tag, ok);
        if (!ok) return;
        sb_q.push_back(exp_of(v));
        w0 = wr_cnt;
        @(negedge clk);
        chk({tag, "_access_valid"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_latency"}, 32'(rsp_valid), 32'd1);
        expect_rsp(tag);
        chk({tag, "_writes"}, 32'(wr_cnt - w0), 32'(v.exp_wr));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bit   ok;
        int   w0;
        vec_t v;

        //          we  f3      addr           wdata          rd     data           flt   cause  wr
        vecs[0]  = '{1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 5'd1,  32'h0000_0000, 1'b0, 2'b00, 1};
        vecs[1]  = '{0, 3'b010, 32'h0000_0010, 32'h0,         5'd2,  32'hDEAD_BEEF, 1'b0, 2'b00, 0};
        vecs[2]  = '{0, 3'b000, 32'h0000_0013, 32'h0,         5'd3,  32'hFFFF_FFDE, 1'b0, 2'b00, 0};
        vecs[3]  = '{0, 3'b100, 32'h0000_0013, 32'h0,         5'd4,  32'h0000_00DE, 1'b0, 2'b00, 0};
        vecs[4]  = '{0, 3'b001, 32'h0000_0012, 32'h0,         5'd5,  32'hFFFF_DEAD, 1'b0, 2'b00, 0};
        vecs[5]  = '{0, 3'b101, 32'h0000_0010, 32'h0,         5'd6,  32'h0000_BEEF, 1'b0, 2'b00, 0};
        vecs[6]  = '{1, 3'b010, 32'h0000_0020, 32'hCAFE_F00D, 5'd7,  32'h0000_0000, 1'b0, 2'b00, 1};
        vecs[7]  = '{0, 3'b010, 32'h0000_0011, 32'h0,         5'd8,  32'h0000_0000, 1'b1, 2'b01, 0};
        vecs[8]  = '{1, 3'b001, 32'h0000_0021, 32'h0000_FFFF, 5'd9,  32'h0000_0000, 1'b1, 2'b01, 0};
        vecs[9]  = '{0, 3'b010, 32'h0000_0020, 32'h0,         5'd10, 32'hCAFE_F00D, 1'b0, 2'b00, 0};
        vecs[10] = '{1, 3'b010, 32'h0000_03FC, 32'h1357_9BDF, 5'd11, 32'h0000_0000, 1'b0, 2'b00, 1};
        vecs[11] = '{0, 3'b010, 32'h0000_03FC, 32'h0,         5'd12, 32'h1357_9BDF, 1'b0, 2'b00, 0};
        vecs[12] = '{0, 3'b010, 32'h0000_0400, 32'h0,         5'd13, 32'h0000_0000, 1'b1, 2'b10, 0};
        vecs[13] = '{1, 3'b000, 32'hFFFF_FFFF, 32'h0000_00AA, 5'd14, 32'h0000_0000, 1'b1, 2'b10, 0};
        vecs[14] = '{1, 3'b100, 32'h0000_0040, 32'h0000_0055, 5'd15, 32'h0000_0000, 1'b1, 2'b11, 0};
        vecs[15] = '{0, 3'b011, 32'h0000_0040, 32'h0,         5'd16, 32'h0000_0000, 1'b1, 2'b11, 0};
        vecs[16] = '{0, 3'b110, 32'h0000_0041, 32'h0,         5'd17, 32'h0000_0000, 1'b1, 2'b11, 0};
        vecs[17] = '{0, 3'b001, 32'h0000_03FF, 32'h0,         5'd18, 32'h0000_0000, 1'b1, 2'b01, 0};
        vecs[18] = '{0, 3'b100, 32'h0000_03FF, 32'h0,         5'd19, 32'h0000_0013, 1'b0, 2'b00, 0};
        vecs[19] = '{1, 3'b010, 32'h0000_0030, 32'h1122_3344, 5'd20, 32'h0000_0000, 1'b0, 2'b00, 1};
        vecs[20] = '{1, 3'b000, 32'h0000_03FD, 32'hFFFF_FFA5, 5'd21, 32'h0000_0000, 1'b0, 2'b00, 1};
        vecs[21] = '{0, 3'b010, 32'h0000_03FC, 32'h0,         5'd22, 32'h1357_A5DF, 1'b0, 2'b00, 0};
        vecs[22] = '{1, 3'b001, 32'h0000_03FE, 32'hBEEF_1234, 5'd23, 32'h0000_0000, 1'b0, 2'b00, 1};
        vecs[23] = '{0, 3'b010, 32'h0000_03FC, 32'h0,         5'd24, 32'h1234_A5DF, 1'b0, 2'b00, 0};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_func3 = 3'b000;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_rd    = 5'd0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready",   32'(req_ready),   32'd1);
        chk("rst_dm_we",       32'(dm_we),       32'd0);
        chk("rst_dm_a",        dm_a,             32'd0);
        chk("rst_dm_wd",       dm_wd,            32'd0);
        chk("rst_dm_func3",    32'(dm_func3),    32'd0);
        chk("rst_rsp_valid",   32'(rsp_valid),   32'd0);
        chk("rst_rsp_data",    rsp_data,         32'd0);
        chk("rst_rsp_rd",      32'(rsp_rd),      32'd0);
        chk("rst_rsp_is_load", 32'(rsp_is_load), 32'd0);
        chk("rst_rsp_fault",   32'(rsp_fault),   32'd0);
        chk("rst_rsp_cause",   32'(rsp_cause),   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            issue(vecs[i], $sformatf("vec%0d", i));
        end

        // Writeback backpressure with a competing request held on the input.
        v = '{0, 3'b010, 32'h0000_0010, 32'h0, 5'd25, 32'hDEAD_BEEF, 1'b0, 2'b00, 0};
        rsp_ready = 1'b0;
        drive_req(v);
        wait_accept("bp", ok);
        if (ok) begin
            sb_q.push_back(exp_of(v));
            w0 = wr_cnt;
            req_we    = 1'b1;
            req_func3 = 3'b010;
            req_addr  = 32'h0000_0010;
            req_wdata = 32'h0000_0000;
            req_rd    = 5'd30;
            req_valid = 1'b1;
            repeat (2) @(negedge clk);
            for (int c = 0; c < 5; c++) begin
                chk($sformatf("bp_valid_%0d", c),     32'(rsp_valid), 32'd1);
                chk($sformatf("bp_req_ready_%0d", c), 32'(req_ready), 32'd0);
                chk($sformatf("bp_data_%0d", c),      rsp_data,       32'hDEAD_BEEF);
                chk($sformatf("bp_rd_%0d", c),        32'(rsp_rd),    32'd25);
                chk($sformatf("bp_fault_%0d", c),     32'(rsp_fault), 32'd0);
                @(negedge clk);
            end
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            @(negedge clk);
            expect_rsp("bp");
            chk("bp_writes", 32'(wr_cnt - w0), 32'd0);
        end
        rsp_ready = 1'b1;
        issue('{0, 3'b010, 32'h0000_0010, 32'h0, 5'd26, 32'hDEAD_BEEF, 1'b0, 2'b00, 0}, "bp_after");

        // Reset during the ACCESS cycle of a store.
        drive_req('{1, 3'b010, 32'h0000_0030, 32'h1234_5678, 5'd27, 32'h0, 1'b0, 2'b00, 0});
        wait_accept("rst_acc", ok);
        if (ok) begin
            rst = 1'b1;
            w0  = wr_cnt;
            @(negedge clk);
            chk("rst_acc_dm_we", 32'(dm_we), 32'd0);
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            chk("rst_acc_req_ready", 32'(req_ready), 32'd1);
            chk("rst_acc_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_acc_writes",    32'(wr_cnt - w0), 32'd0);
            @(posedge clk);
            #1;
        end
        issue('{0, 3'b010, 32'h0000_0030, 32'h0, 5'd28, 32'h1122_3344, 1'b0, 2'b00, 0}, "rst_after");

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
